muldiv_ctrl: RTL and testbench

Sequencing controller between the EX stage and the iterative multiply/divide unit. Accepts one M-extension op at a time from EX, stalls the front of the pipeline while the op is in flight, and launches the unit with a single start pulse. Resolves divide-by-zero, signed overflow and DIV/REM or MULH/MUL operand-reuse pairs in one cycle without the unit. Returns a single result to the EX result mux, holding it under downstream back-pressure.

---
 rtl/muldiv_ctrl_pkg.sv | 57 +++++
 rtl/muldiv_ctrl_special_detect.sv | 38 +++
 rtl/muldiv_ctrl.sv | 157 +++++++++++++++
 tb/tb_muldiv_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared types and helpers for the M-extension sequencing controller.
package muldiv_ctrl_pkg;

  // Encoding follows RISC-V funct3 for the M extension.
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  localparam logic [31:0] MULDIV_ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [31:0] MULDIV_INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] MULDIV_ZERO     = 32'h0000_0000;

  // True when the op wants the hi half (MULH*, REM*); MUL/DIV/DIVU take lo.
  function automatic logic sel_hi(input muldiv_op_t op);
    logic hi;
    if (op[2]) begin
      hi = op[1];
    end else begin
      hi = (op[1:0] != 2'b00);
    end
    return hi;
  endfunction

  // Class under which a unit result is cached: REM folds onto DIV, REMU onto DIVU.
  function automatic muldiv_op_t op_class(input muldiv_op_t op);
    muldiv_op_t cls;
    case (op)
      OP_REM:  cls = OP_DIV;
      OP_REMU: cls = OP_DIVU;
      default: cls = op;
    endcase
    return cls;
  endfunction

  // Whether a cached entry of class cls can answer op. A MUL-class entry only
  // carries a trustworthy lo, so MULH* need an entry of their own signedness.
  function automatic logic cache_family_hit(input muldiv_op_t op, input muldiv_op_t cls);
    logic hit;
    case (op)
      OP_MUL:                       hit = (cls == OP_MUL) || (cls == OP_MULH) ||
                                          (cls == OP_MULHSU) || (cls == OP_MULHU);
      OP_MULH, OP_MULHSU, OP_MULHU: hit = (cls == op);
      OP_DIV, OP_REM:               hit = (cls == OP_DIV);
      OP_DIVU, OP_REMU:             hit = (cls == OP_DIVU);
      default:                      hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_special_detect.sv
// Combinational classifier for divides the unit never needs to see:
// divide-by-zero and signed INT_MIN / -1 overflow, with their fixed lo/hi.
module muldiv_special_detect
  import muldiv_ctrl_pkg::*;
(
  input  muldiv_op_t  op_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  output logic        special_o,
  output logic [31:0] lo_o,
  output logic [31:0] hi_o
);

  logic is_div_s;
  logic is_signed_div_s;

  assign is_div_s        = op_i[2];
  assign is_signed_div_s = (op_i == OP_DIV) || (op_i == OP_REM);

  // Classify the operands and build the architectural quotient/remainder.
  always_comb begin
    special_o = 1'b0;
    lo_o      = MULDIV_ZERO;
    hi_o      = MULDIV_ZERO;
    if (is_div_s && (rs2_i == MULDIV_ZERO)) begin
      special_o = 1'b1;
      lo_o      = MULDIV_ALL_ONES;
      hi_o      = rs1_i;
    end else if (is_signed_div_s && (rs1_i == MULDIV_INT_MIN) && (rs2_i == MULDIV_ALL_ONES)) begin
      special_o = 1'b1;
      lo_o      = MULDIV_INT_MIN;
      hi_o      = MULDIV_ZERO;
    end else begin
      special_o = 1'b0;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer between EX and the iterative multiply/divide unit: one op in
// flight, fast path for special divides and paired-op reuse, result held
// under write-back back-pressure.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter bit REUSE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  muldiv_op_t  ex_op,
  input  logic [31:0] ex_rs1,
  input  logic [31:0] ex_rs2,
  input  logic        ex_flush,
  input  logic        wb_stall,
  output logic        stall_out,
  output logic        result_valid,
  output logic [31:0] result,
  output logic        mdu_start,
  output muldiv_op_t  mdu_op,
  output logic [31:0] mdu_a,
  output logic [31:0] mdu_b,
  input  logic        mdu_ready,
  input  logic [31:0] mdu_lo,
  input  logic [31:0] mdu_hi
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] result_q, result_d;
  logic        cvalid_q, cvalid_d;
  muldiv_op_t  ccls_q, ccls_d;
  logic [31:0] ca_q, ca_d;
  logic [31:0] cb_q, cb_d;
  logic [31:0] clo_q, clo_d;
  logic [31:0] chi_q, chi_d;

  logic        special_s;
  logic [31:0] sp_lo_s;
  logic [31:0] sp_hi_s;
  logic        cache_hit_s;
  logic        start_s;

  muldiv_special_detect u_special (
    .op_i      (ex_op),
    .rs1_i     (ex_rs1),
    .rs2_i     (ex_rs2),
    .special_o (special_s),
    .lo_o      (sp_lo_s),
    .hi_o      (sp_hi_s)
  );

  assign cache_hit_s = REUSE_EN && cvalid_q && (ex_rs1 == ca_q) && (ex_rs2 == cb_q) &&
                       cache_family_hit(ex_op, ccls_q);

  assign mdu_op       = ex_op;
  assign mdu_a        = ex_rs1;
  assign mdu_b        = ex_rs2;
  assign mdu_start    = start_s && !reset;
  assign result_valid = (state_q == S_DONE);
  assign result       = result_q;
  assign stall_out    = !reset && ex_valid && !ex_flush &&
                        !((state_q == S_DONE) && !wb_stall);

  // Next-state, launch pulse, result capture and cache update.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cvalid_d = cvalid_q;
    ccls_d   = ccls_q;
    ca_d     = ca_q;
    cb_d     = cb_q;
    clo_d    = clo_q;
    chi_d    = chi_q;
    start_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ex_valid && !ex_flush) begin
          if (special_s) begin
            result_d = sel_hi(ex_op) ? sp_hi_s : sp_lo_s;
            state_d  = S_DONE;
          end else if (cache_hit_s) begin
            result_d = sel_hi(ex_op) ? chi_q : clo_q;
            state_d  = S_DONE;
          end else begin
            start_s  = 1'b1;
            state_d  = S_BUSY;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (ex_flush) begin
          // A same-cycle completion means the unit is already idle: no drain.
          cvalid_d = 1'b0;
          state_d  = mdu_ready ? S_IDLE : S_DRAIN;
        end else if (mdu_ready) begin
          cvalid_d = 1'b1;
          ccls_d   = op_class(ex_op);
          ca_d     = ex_rs1;
          cb_d     = ex_rs2;
          clo_d    = mdu_lo;
          chi_d    = mdu_hi;
          result_d = sel_hi(ex_op) ? mdu_hi : mdu_lo;
          state_d  = S_DONE;
        end else begin
          state_d = S_BUSY;
        end
      end
      S_DONE: begin
        if (ex_flush || !wb_stall) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DRAIN: begin
        if (mdu_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d  = S_IDLE;
        cvalid_d = 1'b0;
      end
    endcase
  end

  // State, result and reuse-cache registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      result_q <= MULDIV_ZERO;
      cvalid_q <= 1'b0;
      ccls_q   <= OP_MUL;
      ca_q     <= MULDIV_ZERO;
      cb_q     <= MULDIV_ZERO;
      clo_q    <= MULDIV_ZERO;
      chi_q    <= MULDIV_ZERO;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      cvalid_q <= cvalid_d;
      ccls_q   <= ccls_d;
      ca_q     <= ca_d;
      cb_q     <= cb_d;
      clo_q    <= clo_d;
      chi_q    <= chi_d;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl with a behavioural 32-cycle unit model.
`timescale 1ns/1ps
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  localparam int UNIT_LAT = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  muldiv_op_t  ex_op;
  logic [31:0] ex_rs1, ex_rs2;
  logic        ex_flush, wb_stall;
  logic        stall_out, result_valid;
  logic [31:0] result;
  logic        mdu_start;
  muldiv_op_t  mdu_op;
  logic [31:0] mdu_a, mdu_b;
  logic        mdu_ready = 1'b0;
  logic [31:0] mdu_lo = 32'd0, mdu_hi = 32'd0;

  int n_checks = 0;
  int n_pass   = 0;
  int start_cnt = 0;
  logic [31:0] sb_q[$];

  muldiv_ctrl #(.REUSE_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_op(ex_op),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_flush(ex_flush), .wb_stall(wb_stall),
    .stall_out(stall_out), .result_valid(result_valid), .result(result),
    .mdu_start(mdu_start), .mdu_op(mdu_op), .mdu_a(mdu_a), .mdu_b(mdu_b),
    .mdu_ready(mdu_ready), .mdu_lo(mdu_lo), .mdu_hi(mdu_hi)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  // Reference arithmetic for the unit model: returns {hi, lo}.
  function automatic logic [63:0] unit_calc(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] q, r;
    q = 32'd0;
    r = 32'd0;
    case (op)
      OP_MUL, OP_MULH: p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      OP_MULHSU:       p = $signed({{32{a[31]}}, a}) * $signed({32'd0, b});
      OP_MULHU:        p = {32'd0, a} * {32'd0, b};
      OP_DIV, OP_REM: begin
        if (b != 32'd0) begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
        end
        p = {r, q};
      end
      default: begin
        if (b != 32'd0) begin
          q = a / b;
          r = a % b;
        end
        p = {r, q};
      end
    endcase
    return p;
  endfunction

  // Iterative unit model: ready pulse UNIT_LAT cycles after the start cycle.
  logic       m_busy = 1'b0;
  int         m_cnt = 0;
  muldiv_op_t m_op = OP_MUL;
  logic [31:0] m_a = 32'd0, m_b = 32'd0;
  always @(posedge clk) begin
    if (reset) begin
      m_busy    <= 1'b0;
      mdu_ready <= 1'b0;
    end else begin
      mdu_ready <= 1'b0;
      if (m_busy) begin
        if (m_cnt == UNIT_LAT - 1) begin
          mdu_ready <= 1'b1;
          m_busy    <= 1'b0;
          {mdu_hi, mdu_lo} <= unit_calc(m_op, m_a, m_b);
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
      if (mdu_start) begin
        start_cnt <= start_cnt + 1;
        m_busy    <= 1'b1;
        m_cnt     <= 1;
        m_op      <= mdu_op;
        m_a       <= mdu_a;
        m_b       <= mdu_b;
      end
    end
  end

  // Monitor: every accepted result is popped and compared against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && result_valid && !wb_stall && !ex_flush) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_result: got %08h expected no result", result);
        end else begin
          check("result", result, sb_q.pop_front());
        end
      end
    end
  end

  // Present one op, hold it until taken, and check latency/stall/start count.
  task automatic run_op(input string name, input muldiv_op_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_starts,
                        input int exp_lat, input int bp_cycles);
    int   s0, lat;
    logic stall_ok;
    sb_q.push_back(exp);
    @(posedge clk); #1;
    s0 = start_cnt;
    ex_valid = 1'b1; ex_op = op; ex_rs1 = a; ex_rs2 = b;
    wb_stall = (bp_cycles > 0);
    lat = 0;
    stall_ok = 1'b1;
    forever begin
      @(negedge clk);
      if (result_valid || lat > 200) break;
      if (!stall_out) stall_ok = 1'b0;
      lat++;
    end
    check({name, "_valid"}, {31'd0, result_valid}, 32'd1);
    check({name, "_lat"}, lat, exp_lat);
    check({name, "_stall_busy"}, {31'd0, stall_ok}, 32'd1);
    for (int k = 0; k < bp_cycles; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        @(negedge clk);
      end
      check({name, "_bp_valid"}, {31'd0, result_valid}, 32'd1);
      check({name, "_bp_result"}, result, exp);
      check({name, "_bp_stall"}, {31'd0, stall_out}, 32'd1);
    end
    if (bp_cycles > 0) begin
      @(posedge clk); #1;
      wb_stall = 1'b0;
      @(negedge clk);
    end
    check({name, "_stall_done"}, {31'd0, stall_out}, 32'd0);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    check({name, "_starts"}, start_cnt - s0, exp_starts);
  endtask

  initial begin
    int   s0;
    logic drain_ok;
    reset = 1'b1; ex_valid = 1'b0; ex_op = OP_MUL; ex_rs1 = 32'd0; ex_rs2 = 32'd0;
    ex_flush = 1'b0; wb_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_valid", {31'd0, result_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_stall", {31'd0, stall_out}, 32'd0);
    check("rst_start", {31'd0, mdu_start}, 32'd0);

    run_op("div_100_7",    OP_DIV,    32'd100,        32'd7,          32'd14,         1, 33, 0);
    run_op("rem_hit",      OP_REM,    32'd100,        32'd7,          32'd2,          0, 1,  0);
    run_op("divu_by0",     OP_DIVU,   32'd16,         32'd0,          32'hFFFF_FFFF,  0, 1,  0);
    run_op("rem_by0",      OP_REM,    32'd5,          32'd0,          32'd5,          0, 1,  0);
    run_op("div_ovf",      OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  0, 1,  0);
    run_op("rem_ovf",      OP_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          0, 1,  0);
    run_op("mulhu",        OP_MULHU,  32'hFFFF_FFFF,  32'd2,          32'd1,          1, 33, 0);
    run_op("mul_hit",      OP_MUL,    32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  0, 1,  0);
    run_op("mulh_miss",    OP_MULH,   32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  1, 33, 0);
    run_op("mul_3_4",      OP_MUL,    32'd3,          32'd4,          32'd12,         1, 33, 0);

    // Flush in BUSY at t+5, then re-present MUL 3x4 while the unit drains.
    @(posedge clk); #1;
    s0 = start_cnt;
    ex_valid = 1'b1; ex_op = OP_DIV; ex_rs1 = 32'd1000; ex_rs2 = 32'd10;
    repeat (5) @(posedge clk);
    #1 ex_flush = 1'b1;
    @(negedge clk);
    check("flush_stall", {31'd0, stall_out}, 32'd0);
    @(posedge clk); #1;
    ex_flush = 1'b0; ex_op = OP_MUL; ex_rs1 = 32'd3; ex_rs2 = 32'd4;
    drain_ok = 1'b1;
    for (int k = 0; k < 27; k++) begin
      @(negedge clk);
      if (result_valid || !stall_out) drain_ok = 1'b0;
    end
    check("drain_quiet", {31'd0, drain_ok}, 32'd1);
    check("drain_starts", start_cnt - s0, 32'd1);
    run_op("mul_after_flush", OP_MUL, 32'd3, 32'd4, 32'd12, 1, 33, 0);

    // Back-pressure: hit path, wb_stall held three DONE cycles.
    run_op("mul_bp", OP_MUL, 32'd3, 32'd4, 32'd12, 0, 1, 3);

    // Reset ten cycles into a unit op.
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_op = OP_DIVU; ex_rs1 = 32'd200; ex_rs2 = 32'd3;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1; ex_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", {31'd0, result_valid}, 32'd0);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_stall", {31'd0, stall_out}, 32'd0);
    check("mid_rst_start", {31'd0, mdu_start}, 32'd0);
    run_op("mulh_after_rst", OP_MULH, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1, 33, 0);

    repeat (40) @(posedge clk);
    check("sb_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
